// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: FSM states, unit codes and defaults.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        EVAL  = S_EVAL,
        DONE  = S_DONE
    } state_e;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_SHIFT = 2'b10,
        UNIT_NONE  = 2'b11
    } unit_e;

    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic unit_e sel_unit(input logic [4:0] sel);
        return unit_e'(sel[4:3]);
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Saturating latency counter with clear, enable and a terminal-count compare.
module alu_lat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // A clear that coincides with an enable counts that cycle too.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= {{(CNT_W-1){1'b0}}, en};
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt >= term);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer in front of the 64-bit ALU: registers a request, drives the ALU,
// waits for or settles the result and returns it with error and latency info.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both 1; valid, once raised, holds with stable payload until that edge.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [4:0]        req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  rsp_cycles,
    output logic              alu_bgn,
    output logic [DATA_W-1:0] alu_in_0,
    output logic [DATA_W-1:0] alu_in_1,
    output logic [4:0]        alu_sel,
    input  logic              alu_stop,
    input  logic [DATA_W-1:0] alu_out,
    output logic [2:0]        dbg_state
);

    // cnt already holds 2 on WAIT entry (accept + ISSUE), so TIMEOUT_CYCLES
    // full WAIT cycles have elapsed once cnt reaches TIMEOUT_CYCLES + 1.
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES + 1);

    state_e           state;
    logic             accept;
    logic             cnt_en;
    logic             timeout;
    logic [CNT_W-1:0] cnt;

    assign accept = (state == IDLE) && req_valid;
    assign cnt_en = accept || (state == ISSUE) || (state == WAIT) || (state == EVAL);

    alu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (accept),
        .en    (cnt_en),
        .term  (TIMEOUT_TERM),
        .cnt   (cnt),
        .tc    (timeout)
    );

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state    <= IDLE;
            alu_in_0 <= '0;
            alu_in_1 <= '0;
            alu_sel  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_in_0 <= req_a;
                        alu_in_1 <= req_b;
                        alu_sel  <= req_sel;
                        case (sel_unit(req_sel))
                            UNIT_ARITH: state <= ISSUE;
                            UNIT_LOGIC,
                            UNIT_SHIFT: state <= EVAL;
                            default: begin
                                rsp_data <= '0;
                                rsp_err  <= 1'b1;
                                state    <= DONE;
                            end
                        endcase
                    end
                end
                // alu_stop may still be high from the previous op; not sampled here.
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (alu_stop) begin
                        rsp_data <= alu_out;
                        rsp_err  <= 1'b0;
                        state    <= DONE;
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= DONE;
                    end
                end
                EVAL: begin
                    rsp_data <= alu_out;
                    rsp_err  <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign alu_bgn    = (state == ISSUE);
    assign rsp_valid  = (state == DONE);
    assign rsp_cycles = cnt;
    assign dbg_state  = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an ALU stub, expected-response queue and monitor.
module tb_alu_issue_ctrl;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int EXP_W  = 1 + CNT_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_b = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic [4:0]        req_sel = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [CNT_W-1:0]  rsp_cycles;
    logic              alu_bgn;
    logic [DATA_W-1:0] alu_in_0;
    logic [DATA_W-1:0] alu_in_1;
    logic [4:0]        alu_sel;
    logic              alu_stop;
    logic [DATA_W-1:0] alu_out;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_rsp = 0;
    int bgn_cnt = 0;

    logic [EXP_W-1:0]  exp_q[$];
    logic              stub_en = 1'b1;
    logic [DATA_W-1:0] logic_val = '0;
    logic [2:0]        stop_dly;

    alu_issue_ctrl #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .rsp_cycles (rsp_cycles),
        .alu_bgn    (alu_bgn),
        .alu_in_0   (alu_in_0),
        .alu_in_1   (alu_in_1),
        .alu_sel    (alu_sel),
        .alu_stop   (alu_stop),
        .alu_out    (alu_out),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // ALU stub: stop rises 5 cycles after the begin pulse and stays high.
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            alu_stop <= 1'b0;
            stop_dly <= '0;
        end else if (alu_bgn) begin
            alu_stop <= 1'b0;
            stop_dly <= stub_en ? 3'd4 : 3'd0;
        end else if (stop_dly != 0) begin
            stop_dly <= stop_dly - 1'b1;
            if (stop_dly == 3'd1) alu_stop <= 1'b1;
        end
    end

    assign alu_out = (alu_sel[4:3] == 2'b00) ? (alu_in_0 + alu_in_1) : logic_val;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected response per rsp handshake
    always @(negedge clk) begin
        if (alu_bgn) bgn_cnt++;
        if (!rst_b && rsp_valid && rsp_ready) begin
            n_rsp++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected: got data=%0h err=%0b cycles=%0d expected no response",
                         rsp_data, rsp_err, rsp_cycles);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if ({rsp_err, rsp_cycles, rsp_data} !== e) begin
                    n_bad++;
                    $display("FAIL rsp: got err=%0b cycles=%0d data=%0h expected err=%0b cycles=%0d data=%0h",
                             rsp_err, rsp_cycles, rsp_data,
                             e[EXP_W-1], e[EXP_W-2 -: CNT_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    function automatic logic [EXP_W-1:0] mk_exp(input logic err, input int cyc, input logic [DATA_W-1:0] data);
        return {err, CNT_W'(cyc), data};
    endfunction

    // driver: present a request and return #1 after the accepting edge
    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [4:0] sel,
                        input logic push, input logic [EXP_W-1:0] exp);
        logic acc;
        if (push) exp_q.push_back(exp);
        req_a = a;
        req_b = b;
        req_sel = sel;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int i;
        for (i = 0; i < 100 && n_rsp < target; i++) @(negedge clk);
        if (n_rsp < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_wait_timeout: got %0d responses expected %0d", n_rsp, target);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        int r0;
        logic seen;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_alu_bgn", 64'(alu_bgn), 64'd0);
        chk("reset_alu_in_0", alu_in_0, 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_cycles", 64'(rsp_cycles), 64'd0);
        rst_b = 1'b0;
        @(posedge clk);
        #1;

        // arithmetic: 7 + 9, accept + ISSUE + 5 stop-delay cycles
        b0 = bgn_cnt;
        send(64'd7, 64'd9, 5'b00000, 1'b1, mk_exp(1'b0, 7, 64'd16));
        wait_rsp(1);
        chk("arith_bgn_pulses", 64'(bgn_cnt - b0), 64'd1);

        // second arithmetic op with stop still high from the first
        b0 = bgn_cnt;
        send(64'd100, 64'd23, 5'b00101, 1'b1, mk_exp(1'b0, 7, 64'd123));
        wait_rsp(2);
        chk("arith2_bgn_pulses", 64'(bgn_cnt - b0), 64'd1);

        // logic unit settles in one EVAL cycle
        logic_val = 64'h00FF_00FF_00FF_00FF;
        b0 = bgn_cnt;
        send(64'd1, 64'd2, 5'b01000, 1'b1, mk_exp(1'b0, 2, 64'h00FF_00FF_00FF_00FF));
        wait_rsp(3);
        chk("logic_bgn_pulses", 64'(bgn_cnt - b0), 64'd0);

        // shift unit
        logic_val = 64'h0000_1234_5678_9ABC;
        send(64'd5, 64'd6, 5'b10011, 1'b1, mk_exp(1'b0, 2, 64'h0000_1234_5678_9ABC));
        wait_rsp(4);

        // illegal unit: immediate error, zero data
        logic_val = 64'hDEAD_BEEF_0000_0001;
        b0 = bgn_cnt;
        send(64'd11, 64'd12, 5'b11010, 1'b1, mk_exp(1'b1, 1, 64'd0));
        wait_rsp(5);
        chk("illegal_bgn_pulses", 64'(bgn_cnt - b0), 64'd0);

        // timeout: no stop, 8 WAIT cycles after accept + ISSUE
        stub_en = 1'b0;
        send(64'd1, 64'd2, 5'b00000, 1'b1, mk_exp(1'b1, 10, 64'd0));
        wait_rsp(6);
        stub_en = 1'b1;
        chk("timeout_back_idle", 64'(req_ready), 64'd1);
        chk("operand_hold_in_0", alu_in_0, 64'd1);
        chk("operand_hold_in_1", alu_in_1, 64'd2);

        // backpressure, then a second request held during DONE
        r0 = n_rsp;
        rsp_ready = 1'b0;
        logic_val = 64'hA5A5_0000_FFFF_1111;
        send(64'd3, 64'd4, 5'b00000, 1'b1, mk_exp(1'b0, 7, 64'd7));
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("bp_rsp_valid_seen", 64'(seen), 64'd1);
        exp_q.push_back(mk_exp(1'b0, 2, 64'hA5A5_0000_FFFF_1111));
        req_a = 64'd40;
        req_b = 64'd50;
        req_sel = 5'b01000;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_data", rsp_data, 64'd7);
            chk("bp_rsp_err", 64'(rsp_err), 64'd0);
            chk("bp_rsp_cycles", 64'(rsp_cycles), 64'd7);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_alu_sel_held", 64'(alu_sel), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_ready", 64'(req_ready), 64'd1);
        chk("b2b_not_yet_accepted", 64'(alu_sel), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_accepted_sel", 64'(alu_sel), 64'(5'b01000));
        chk("b2b_accepted_in_0", alu_in_0, 64'd40);
        chk("b2b_busy", 64'(req_ready), 64'd0);
        wait_rsp(r0 + 2);

        // reset two cycles after the begin pulse abandons the op
        send(64'd8, 64'd8, 5'b00000, 1'b0, '0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (alu_bgn) seen = 1'b1;
        end
        chk("rst_bgn_seen", 64'(seen), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        #1;
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_alu_bgn", 64'(alu_bgn), 64'd0);
        chk("rst_mid_alu_in_0", alu_in_0, 64'd0);
        chk("rst_mid_alu_sel", 64'(alu_sel), 64'd0);
        chk("rst_mid_rsp_cycles", 64'(rsp_cycles), 64'd0);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        r0 = n_rsp;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("rst_no_rsp_valid", 64'(seen), 64'd0);
        chk("rst_no_rsp_handshake", 64'(n_rsp - r0), 64'd0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1, "bench time limit");
    end

endmodule
